bitboard_scan_seq: RTL and testbench



---
 rtl/bitboard_scan_seq_if.sv | 28 ++
 rtl/bitboard_scan_seq.sv | 95 +++++++++
 tb/tb_bitboard_scan_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bitboard_scan_seq_if.sv
// Load/abort request and square-stream bundle for bitboard_scan_seq.
// The master modport is the producer/consumer side, and the slave modport is the sequencer side.
interface bitboard_scan_seq_if #(
  parameter int WIDTH = 64,
  parameter int IDXW  = 6
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_mask;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sel;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             done;
  logic [IDXW:0]    count;

  modport master (
    output load_valid, load_mask, abort, out_ready,
    input  load_ready, out_valid, out_sel, out_idx, out_last, done, count
  );

  modport slave (
    input  load_valid, load_mask, abort, out_ready,
    output load_ready, out_valid, out_sel, out_idx, out_last, done, count
  );
endinterface

// File: rtl/bitboard_scan_seq.sv
// Emits the set bits of a mask lowest-first, one per cycle, starting the cycle after the load.
// A square holds stable while out_ready is low; abort drops the scan, and load is accepted only in IDLE.
module bitboard_scan_seq #(
  parameter int WIDTH = 64,
  parameter int IDXW  = 6
) (
  input  logic                clk,
  input  logic                rst,
  bitboard_scan_seq_if.slave  bus
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem, rem_n, rem_m1, rem_clr;
  logic [IDXW:0]    count_q, count_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] sel;
  logic [IDXW-1:0]  idx;
  logic             scan, last, beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      count_q <= count_n;
      done_q  <= done_n;
    end
  end

  // Lowest set bit isolation; rem_clr is the residual mask after removing it
  always_comb begin
    scan    = (state == SCAN);
    rem_m1  = rem - 1'b1;
    rem_clr = rem & rem_m1;
    sel     = scan ? (rem & ~rem_m1) : '0;
    last    = scan && (rem_clr == '0);
    beat    = scan && bus.out_ready && !bus.abort;
    idx     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) idx = IDXW'(i);
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    count_n = count_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // abort in IDLE has no effect on its own, but it blocks a same-cycle load
        if (bus.load_valid && !bus.abort) begin
          count_n = '0;
          if (bus.load_mask != '0) begin
            rem_n   = bus.load_mask;
            state_n = SCAN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_n = IDLE;
          rem_n   = '0;
        end else if (beat) begin
          rem_n   = rem_clr;
          count_n = count_q + 1'b1;
          if (last) begin
            state_n = IDLE;
            rem_n   = '0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        rem_n   = '0;
      end
    endcase
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.out_valid  = scan;
  assign bus.out_sel    = sel;
  assign bus.out_idx    = idx;
  assign bus.out_last   = last;
  assign bus.done       = done_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_bitboard_scan_seq.sv
// Directed and randomized scans of bitboard_scan_seq checked against a queue-of-indices model.
module tb_bitboard_scan_seq;
  localparam int WIDTH = 64;
  localparam int IDXW  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bitboard_scan_seq_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  bitboard_scan_seq #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset_values(input string tag);
    chk({tag, "_load_ready"}, 64'(bus.load_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_sel"}, bus.out_sel, 64'd0);
    chk({tag, "_out_idx"}, 64'(bus.out_idx), 64'd0);
    chk({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
  endtask

  // Loads mask, then runs the stream: rdy_pct is consumer readiness, hold0 forces
  // out_ready low for that many cycles on the first square, abort_at aborts at that beat (-1 = never).
  task automatic scan(input logic [63:0] mask, input int rdy_pct, input int hold0, input int abort_at);
    int q[$];
    int cnt = 0;
    int held = 0;
    int edges = 0;
    int k;
    for (int i = 0; i < WIDTH; i++) if (mask[i]) q.push_back(i);
    k = q.size();
    bus.abort      = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_mask  = mask;
    chk("load_ready_pre", 64'(bus.load_ready), 64'd1);
    step();
    edges++;
    bus.load_valid = 1'b0;
    if (k == 0) begin
      chk("zero_done", 64'(bus.done), 64'd1);
      chk("zero_out_valid", 64'(bus.out_valid), 64'd0);
      chk("zero_count", 64'(bus.count), 64'd0);
      chk("zero_load_ready", 64'(bus.load_ready), 64'd1);
      step();
      chk("zero_done_clear", 64'(bus.done), 64'd0);
      return;
    end
    while (q.size() > 0) begin
      chk("out_valid", 64'(bus.out_valid), 64'd1);
      chk("out_idx", 64'(bus.out_idx), 64'(q[0]));
      chk("out_sel", bus.out_sel, 64'd1 << q[0]);
      chk("out_last", 64'(bus.out_last), 64'(q.size() == 1));
      chk("scan_load_ready", 64'(bus.load_ready), 64'd0);
      chk("scan_done", 64'(bus.done), 64'd0);
      chk("scan_count", 64'(bus.count), 64'(cnt));
      if (cnt == abort_at) begin
        bus.out_ready = 1'b1;
        bus.abort     = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_load_ready", 64'(bus.load_ready), 64'd1);
        chk("abort_count", 64'(bus.count), 64'(cnt));
        chk("abort_done", 64'(bus.done), 64'd0);
        return;
      end
      if (cnt == 0 && held < hold0) begin
        bus.out_ready = 1'b0;
        held++;
      end else begin
        bus.out_ready = ($urandom_range(99) < rdy_pct);
      end
      // loads offered mid-scan must be ignored
      bus.load_valid = $urandom_range(1);
      bus.load_mask  = {$urandom, $urandom};
      step();
      edges++;
      if (bus.out_ready) begin
        void'(q.pop_front());
        cnt++;
      end
    end
    bus.load_valid = 1'b0;
    chk("end_done", 64'(bus.done), 64'd1);
    chk("end_load_ready", 64'(bus.load_ready), 64'd1);
    chk("end_out_valid", 64'(bus.out_valid), 64'd0);
    chk("end_count", 64'(bus.count), 64'(k));
    if (rdy_pct >= 100 && hold0 == 0) chk("done_latency", 64'(edges), 64'(k + 1));
    step();
    chk("post_done_clear", 64'(bus.done), 64'd0);
    chk("post_count_hold", 64'(bus.count), 64'(k));
  endtask

  initial begin
    logic [63:0] m;
    bus.load_valid = 1'b0;
    bus.load_mask  = '0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;
    #2;
    chk_idle_reset_values("reset");
    step();
    rst = 1'b0;
    step();
    chk_idle_reset_values("after_reset");

    scan(64'h0000_0000_0000_0091, 100, 0, -1);
    scan(64'h8000_0000_0000_0001, 100, 5, -1);
    scan(64'hFFFF_FFFF_FFFF_FFFF, 100, 0, -1);
    scan(64'h0, 100, 0, -1);
    scan(64'h0F0, 100, 0, 1);
    scan(64'h2, 100, 0, -1);

    // abort wins over a simultaneous load in IDLE
    bus.abort      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_mask  = 64'h55;
    step();
    bus.abort      = 1'b0;
    bus.load_valid = 1'b0;
    chk("abort_idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_idle_load_ready", 64'(bus.load_ready), 64'd1);
    chk("abort_idle_count", 64'(bus.count), 64'd1);
    chk("abort_idle_done", 64'(bus.done), 64'd0);

    for (int n = 0; n < 20; n++) begin
      m = {$urandom, $urandom};
      if (n % 3 == 0) m = m & {$urandom, $urandom} & {$urandom, $urandom};
      if (n % 7 == 6) m = '0;
      scan(m, $urandom_range(100, 30), $urandom_range(3), (n % 5 == 4) ? 2 : -1);
    end

    // asynchronous reset in the middle of the first beat of a scan
    scan(64'h3, 100, 0, -1);
    bus.load_valid = 1'b1;
    bus.load_mask  = 64'hC00;
    step();
    bus.load_valid = 1'b1;
    bus.out_ready  = 1'b1;
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    chk("rst_pre_idx", 64'(bus.out_idx), 64'd10);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_reset_values("async_rst");
    step();
    step();
    chk("rst_hold_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_hold_load_ready", 64'(bus.load_ready), 64'd1);
    bus.load_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_idle_reset_values("rst_release");
    scan(64'h2, 100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
